mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_if.sv | 26 ++
 rtl/mem_lsu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_if.sv
// Data-bus request/response bundle between the load/store unit and memory.
// Combinational wires only; no latency of its own.
// Backpressure: the master holds req and its fields until gnt is seen.
interface mem_lsu_dbus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dbus_req_o;
    logic              dbus_we_o;
    logic [ADDR_W-1:0] dbus_addr_o;
    logic [3:0]        dbus_be_o;
    logic [DATA_W-1:0] dbus_wdata_o;
    logic              dbus_gnt_i;
    logic              dbus_rvalid_i;
    logic [DATA_W-1:0] dbus_rdata_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );

    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: exe/mem request -> data bus -> registered mem/wb writeback.
// Latency: 1 cycle for NOPs; loads/stores complete in the rvalid cycle.
// Backpressure: stall_req_o holds the pipeline until rvalid; MEM_LSU_MISALIGN_TRAP_EN traps misaligned ops.
module mem_lsu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               reg_we_i,
    input  logic [DATA_W-1:0]  reg_wdata_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_data_i,
    input  logic               mem_we_i,
    input  logic [3:0]         mem_op_i,
    mem_lsu_dbus_if.master     dbus,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               reg_we_o,
    output logic [DATA_W-1:0]  reg_wdata_o,
    output logic               stall_req_o,
    output logic               misalign_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state_q, state_d;
    logic                is_load, is_store, is_half, is_word, is_mem, trap, start, complete;
    logic [1:0]          ea_off;
    logic [3:0]          be_d, be_q, op_q;
    logic [DATA_W-1:0]   wdata_d, wdata_q, lane, load_data;
    logic [ADDR_W-1:0]   addr_q;
    logic [RADDR_W-1:0]  waddr_q;
    logic                we_q, store_q;
    logic                unused_mem_we;

    // The op code alone decides direction; mem_we_i is redundant with it.
    assign unused_mem_we = mem_we_i;

    always_comb begin
        is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
        is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        is_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
        is_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    end

    assign is_mem = is_load | is_store;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign trap = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign start = is_mem & ~trap;

    // Misaligned halfword/word addresses are rounded down to their natural boundary.
    always_comb begin
        ea_off = mem_addr_i[1:0];
        if (is_word)      ea_off    = 2'b00;
        else if (is_half) ea_off[0] = 1'b0;
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = mem_data_i;
        case (mem_op_i)
            OP_SB: begin
                be_d    = 4'b0001 << ea_off;
                wdata_d = {4{mem_data_i[7:0]}};
            end
            OP_SH: begin
                be_d    = 4'b0011 << {ea_off[1], 1'b0};
                wdata_d = {2{mem_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            store_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            addr_q  <= {mem_addr_i[ADDR_W-1:2], ea_off};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            op_q    <= mem_op_i;
            waddr_q <= reg_waddr_i;
            we_q    <= reg_we_i;
            store_q <= is_store;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (dbus.dbus_gnt_i) state_d = dbus.dbus_rvalid_i ? IDLE : WAIT;
            WAIT:    if (dbus.dbus_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_req_o       = 1'b0;
        dbus.dbus_req_o   = 1'b0;
        dbus.dbus_we_o    = 1'b0;
        dbus.dbus_addr_o  = '0;
        dbus.dbus_be_o    = '0;
        dbus.dbus_wdata_o = '0;
        case (state_q)
            IDLE: stall_req_o = start;
            REQ: begin
                stall_req_o       = ~(dbus.dbus_gnt_i & dbus.dbus_rvalid_i);
                dbus.dbus_req_o   = 1'b1;
                dbus.dbus_we_o    = store_q;
                dbus.dbus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                dbus.dbus_be_o    = be_q;
                dbus.dbus_wdata_o = wdata_q;
            end
            WAIT:    stall_req_o = ~dbus.dbus_rvalid_i;
            default: ;
        endcase
        if (!rst_i) stall_req_o = 1'b0;
    end

    assign complete = ((state_q == REQ) && dbus.dbus_gnt_i && dbus.dbus_rvalid_i) ||
                      ((state_q == WAIT) && dbus.dbus_rvalid_i);

    assign lane = dbus.dbus_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (op_q)
            OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  load_data = {24'd0, lane[7:0]};
            OP_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            reg_waddr_o <= '0;
            reg_we_o    <= 1'b0;
            reg_wdata_o <= '0;
            misalign_o  <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            if (state_q == IDLE) begin
                reg_waddr_o <= reg_waddr_i;
                reg_wdata_o <= reg_wdata_i;
                reg_we_o    <= reg_we_i & ~is_mem;
                misalign_o  <= trap;
            end else if (complete && !store_q) begin
                reg_waddr_o <= waddr_q;
                reg_we_o    <= we_q;
                reg_wdata_o <= load_data;
            end else begin
                reg_we_o <= 1'b0;
            end
        end
    end
endmodule
